// File: rtl/md_sched.sv
// md_sched: multi-cycle multiply/divide scheduler for the E stage.
// Owns the architectural HI/LO registers. Computes the result when a request
// is accepted, holds it as a pending value while a busy countdown runs, and
// commits it to HI/LO on the same edge that busy falls. Also generates the
// D-stage stall request for any instruction that needs the MD unit while the
// unit is accepting a request or busy.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_uses_md,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_stall
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Signed 32x32 -> 64 product; operands are sign-extended so the
  // modulo-2^64 product equals the two's-complement result.
  function automatic logic [63:0] mul_signed(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = {{32{a[31]}}, a};
    bx = {{32{b[31]}}, b};
    return ax * bx;
  endfunction

  // Unsigned 32x32 -> 64 product.
  function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = {32'h0, a};
    bx = {32'h0, b};
    return ax * bx;
  endfunction

  // Signed divide returning {remainder, quotient}. Truncates toward zero,
  // remainder follows the dividend's sign. The single overflowing case
  // (most-negative / -1) is pinned to quotient = dividend, remainder = 0 so
  // the result never depends on tool-specific overflow behaviour.
  function automatic logic [63:0] div_signed(input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    logic signed [31:0] q;
    logic signed [31:0] r;
    if ((a == 32'sh8000_0000) && (b == -32'sd1)) begin
      q = a;
      r = 32'sd0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Unsigned divide returning {remainder, quotient}.
  function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    q = a / b;
    r = a % b;
    return {r, q};
  endfunction

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [31:0]        hi_nxt;
  logic [31:0]        lo_nxt;
  logic [31:0]        pend_hi;
  logic [31:0]        pend_hi_nxt;
  logic [31:0]        pend_lo;
  logic [31:0]        pend_lo_nxt;

  logic [63:0]        res_mult;
  logic [63:0]        res_multu;
  logic [63:0]        res_div;
  logic [63:0]        res_divu;
  logic               rt_zero;

  // Candidate results for every MD operation, evaluated from the forwarded operands.
  always_comb begin
    res_mult  = mul_signed(rs_val, rt_val);
    res_multu = mul_unsigned(rs_val, rt_val);
    res_div   = div_signed(rs_val, rt_val);
    res_divu  = div_unsigned(rs_val, rt_val);
    rt_zero   = (rt_val == 32'h0);
  end

  // Next-state and next-value logic: accept in IDLE, count down in RUN.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hi_nxt      = hi;
    lo_nxt      = lo;
    pend_hi_nxt = pend_hi;
    pend_lo_nxt = pend_lo;

    case (state)
      IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT: begin
              pend_hi_nxt = res_mult[63:32];
              pend_lo_nxt = res_mult[31:0];
              cnt_nxt     = CNT_W'(MULT_CYCLES);
              state_nxt   = RUN;
            end
            OP_MULTU: begin
              pend_hi_nxt = res_multu[63:32];
              pend_lo_nxt = res_multu[31:0];
              cnt_nxt     = CNT_W'(MULT_CYCLES);
              state_nxt   = RUN;
            end
            OP_DIV: begin
              // Divide by zero keeps HI/LO as they are but still burns the full latency.
              pend_hi_nxt = rt_zero ? hi : res_div[63:32];
              pend_lo_nxt = rt_zero ? lo : res_div[31:0];
              cnt_nxt     = CNT_W'(DIV_CYCLES);
              state_nxt   = RUN;
            end
            OP_DIVU: begin
              pend_hi_nxt = rt_zero ? hi : res_divu[63:32];
              pend_lo_nxt = rt_zero ? lo : res_divu[31:0];
              cnt_nxt     = CNT_W'(DIV_CYCLES);
              state_nxt   = RUN;
            end
            OP_MTHI: hi_nxt = rs_val;
            OP_MTLO: lo_nxt = rs_val;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Any start seen here is dropped; only the countdown advances.
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          hi_nxt    = pend_hi;
          lo_nxt    = pend_lo;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter, pending result and HI/LO registers; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= 32'h0;
      lo      <= 32'h0;
      pend_hi <= 32'h0;
      pend_lo <= 32'h0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      hi      <= hi_nxt;
      lo      <= lo_nxt;
      pend_hi <= pend_hi_nxt;
      pend_lo <= pend_lo_nxt;
    end
  end

  assign busy     = (state == RUN);
  assign md_stall = d_uses_md & (start | busy);

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed bench for md_sched. A behavioural model tracks HI/LO
// and the remaining busy cycles from the operation rules; a per-cycle compare
// process checks the DUT against it, and directed sequences check literal values.
module tb_md_sched;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_uses_md;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        md_stall;

  int checks   = 0;
  int failures = 0;

  md_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .md_op     (md_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .d_uses_md (d_uses_md),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .md_stall  (md_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]     m_hi;
  logic [31:0]     m_lo;
  logic [31:0]     p_hi;
  logic [31:0]     p_lo;
  int              m_rem;
  longint          sprod;
  longint unsigned uprod;
  int              sq;
  int              sr;

  initial begin
    m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; m_rem = 0;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (start) begin
      case (md_op)
        3'd0: begin
          sprod = longint'($signed(rs_val)) * longint'($signed(rt_val));
          p_hi = sprod[63:32]; p_lo = sprod[31:0]; m_rem = MULT_N;
        end
        3'd1: begin
          uprod = longint'({32'h0, rs_val}) * longint'({32'h0, rt_val});
          p_hi = uprod[63:32]; p_lo = uprod[31:0]; m_rem = MULT_N;
        end
        3'd2: begin
          if (rt_val == 0) begin
            p_hi = m_hi; p_lo = m_lo;
          end else begin
            sq = int'($signed(rs_val)) / int'($signed(rt_val));
            sr = int'($signed(rs_val)) % int'($signed(rt_val));
            p_hi = sr; p_lo = sq;
          end
          m_rem = DIV_N;
        end
        3'd3: begin
          if (rt_val == 0) begin
            p_hi = m_hi; p_lo = m_lo;
          end else begin
            p_hi = rs_val % rt_val; p_lo = rs_val / rt_val;
          end
          m_rem = DIV_N;
        end
        3'd4: m_hi = rs_val;
        3'd5: m_lo = rs_val;
        default: ;
      endcase
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    check("cyc_busy",  {31'h0, busy},     {31'h0, (m_rem != 0)});
    check("cyc_hi",    hi,                m_hi);
    check("cyc_lo",    lo,                m_lo);
    check("cyc_stall", {31'h0, md_stall}, {31'h0, (d_uses_md && (start || m_rem != 0))});
  end

  // ---------------- directed stimulus ----------------
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  int n;

  initial begin
    start = 0; md_op = 0; rs_val = 0; rt_val = 0; d_uses_md = 0;
    reset = 1'b1;
    #4;
    reset = 1'b0;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);

    // Reset in the middle of a running multiply.
    issue(3'd0, 32'd3, 32'd5);
    check("midrun_busy_before", {31'h0, busy}, 32'h1);
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    check("midrun_busy", {31'h0, busy}, 32'h0);
    check("midrun_hi", hi, 32'h0);
    check("midrun_lo", lo, 32'h0);
    #3 reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("midrun_late_busy", {31'h0, busy}, 32'h0);
    check("midrun_late_hi", hi, 32'h0);
    check("midrun_late_lo", lo, 32'h0);

    // Signed multiply latency and result.
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    count_busy(n);
    check("mult_cycles", n, 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    check("model_mult_hi", m_hi, 32'hFFFF_FFFF);

    // Unsigned multiply on the same operands.
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    count_busy(n);
    check("multu_cycles", n, 32'd5);
    check("multu_hi", hi, 32'h0000_0002);
    check("multu_lo", lo, 32'hFFFF_FFFA);

    // Signed divide -7 / 2.
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    check("div_cycles", n, 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("model_div_lo", m_lo, 32'hFFFF_FFFD);

    // Unsigned divide 100 / 7.
    issue(3'd3, 32'd100, 32'd7);
    count_busy(n);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    // Divide by zero keeps HI/LO.
    issue(3'd4, 32'h11, 32'h0);
    check("mthi_hi", hi, 32'h11);
    check("mthi_busy", {31'h0, busy}, 32'h0);
    issue(3'd5, 32'h22, 32'h0);
    check("mtlo_lo", lo, 32'h22);
    issue(3'd3, 32'd50, 32'h0);
    count_busy(n);
    check("div0_cycles", n, 32'd10);
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);

    // Stall during a multiply, with a start ignored while busy.
    d_uses_md = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; md_op = 3'd0; rs_val = 32'h0001_0000; rt_val = 32'h0003_0000;
    #1;
    check("stall_accept", {31'h0, md_stall}, 32'h1);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      check("stall_busy", {31'h0, md_stall}, 32'h1);
      n++;
      if (n == 2) begin
        start = 1'b1; md_op = 3'd4; rs_val = 32'hAB;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("stall_cycles", n, 32'd5);
    check("stall_after", {31'h0, md_stall}, 32'h0);
    check("ignored_hi", hi, 32'h0000_0003);
    check("ignored_lo", lo, 32'h0000_0000);
    check("ignored_busy", {31'h0, busy}, 32'h0);

    // mtlo with a D-stage MD user: stall only in the start cycle.
    @(posedge clk); #1;
    start = 1'b1; md_op = 3'd5; rs_val = 32'h1234;
    #1;
    check("mtlo_stall_start", {31'h0, md_stall}, 32'h1);
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    check("mtlo2_lo", lo, 32'h1234);
    check("mtlo2_busy", {31'h0, busy}, 32'h0);
    check("mtlo2_stall", {31'h0, md_stall}, 32'h0);
    d_uses_md = 1'b0;

    // Undefined opcode is a no-op.
    issue(3'd6, 32'hDEAD_BEEF, 32'h1);
    check("nop_busy", {31'h0, busy}, 32'h0);
    check("nop_hi", hi, 32'h0000_0003);
    check("nop_lo", lo, 32'h1234);

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multi-cycle multiply/divide scheduler for the pipelined MIPS CPU. Sits in the E stage.
- Accepts mult/multu/div/divu/mthi/mtlo requests from E.
- Owns the HI/LO registers and sequences the busy countdown.
- Generates the D-stage stall request for any instruction that needs the MD unit while it is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  E-stage MD instruction valid this cycle
- md_op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, others=no-op
- rs_val  input  32  forwarded rs operand
- rt_val  input  32  forwarded rt operand
- d_uses_md  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  output  1  countdown in progress
- hi  output  32  architectural HI
- lo  output  32  architectural LO
- md_stall  output  1  = d_uses_md & (start | busy); combinational

Behaviour:
- Async reset, in effect immediately, regardless of in-flight operation:
  - busy=0, hi=0, lo=0, counter=0
  - pending result discarded, state=IDLE
- States: IDLE, RUN.
- IDLE, start=1 with md_op 0..3 (accepted on clk edge):
  - Compute the result at accept time into pending_hi/pending_lo.
  - mult: signed 64-bit product of rs_val and rt_val; hi=[63:32], lo=[31:0].
  - multu: same, unsigned.
  - div: lo=signed quotient, hi=signed remainder, truncate toward zero; remainder takes the sign of the dividend.
  - divu: same, unsigned.
  - div/divu with rt_val==0: pending = current hi/lo, so HI/LO are unchanged at completion; busy timing is still applied.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN; busy=1 from the next cycle.
- RUN:
  - Decrement counter each edge.
  - On the edge where counter==1: hi<=pending_hi, lo<=pending_lo, busy<=0, go to IDLE.
  - busy is therefore high for exactly N cycles after the accept edge.
  - New HI/LO values are visible on the same edge busy falls.
- mthi/mtlo in IDLE with start=1: hi<=rs_val (mthi) or lo<=rs_val (mtlo) on that edge. No busy; stays IDLE.
- start while busy=1: ignored.
  - The hazard logic guarantees this cannot happen, but the block must not corrupt state if it does.
  - The bench checks that hi/lo/busy are unaffected.
- start with md_op 6/7: no-op.
- md_stall:
  - High when d_uses_md and the unit is either accepting this cycle (start) or busy.
  - During the final busy cycle md_stall is still 1.
  - The D instruction proceeds the cycle after busy falls.
- hi/lo outputs are register outputs. No bypass of pending values.

Test Plan:
- Reset mid-RUN:
  - Stimulus: reset=1 for 4 time units, then start mult rs=3, rt=5; assert reset again 2 cycles later.
  - Required response: busy=0, hi=0, lo=0 immediately (async); no later update.
- Mult latency:
  - Stimulus: start mult, rs=0xFFFFFFFE (-2), rt=3.
  - Required response: busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. With multu on the same operands: hi=0x00000002, lo=0xFFFFFFFA.
- Signed div:
  - Stimulus: start div, rs=-7 (0xFFFFFFF9), rt=2.
  - Required response: after 10 busy cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- Divide by zero:
  - Stimulus: prior hi=0x11, lo=0x22; start divu, rt=0.
  - Required response: busy=1 for 10 cycles; hi=0x11, lo=0x22 afterward.
- Stall and ignored start:
  - Stimulus: d_uses_md=1 during a mult; issue start mthi, rs=0xAB while busy.
  - Required response: md_stall=1 on the accept cycle and every busy cycle, 0 the cycle after busy falls; hi equals the mult result, not 0xAB.
- mthi/mtlo:
  - Stimulus: start mtlo, rs=0x1234 in IDLE.
  - Required response: lo=0x1234 on the next edge; busy stays 0; md_stall=1 only in the start cycle when d_uses_md=1.
